// File: rtl/add_fp16_arbiter_if.sv
// rtl/add_fp16_arbiter_if.sv - requester, adder and status signals of the shared FP16 adder arbiter
interface add_fp16_arbiter_if #(
  parameter int NREQ = 4
);
  logic               hold;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*16-1:0] req_a;
  logic [NREQ*16-1:0] req_b;
  logic [NREQ-1:0]    resp_valid;
  logic [15:0]        resp_data;
  logic               add_start;
  logic [15:0]        add_fp1;
  logic [15:0]        add_fp2;
  logic [15:0]        add_out;
  logic               busy;

  // arbiter side
  modport slave (
    input  hold, req_valid, req_a, req_b, add_out,
    output req_ready, resp_valid, resp_data, add_start, add_fp1, add_fp2, busy
  );

  // requesters plus adder side
  modport master (
    output hold, req_valid, req_a, req_b, add_out,
    input  req_ready, resp_valid, resp_data, add_start, add_fp1, add_fp2, busy
  );
endinterface

// File: rtl/add_fp16_arbiter.sv
// rtl/add_fp16_arbiter.sv - round-robin front end sharing one add_fp16 among NREQ requesters
module add_fp16_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 2
) (
  input  logic              clk,
  input  logic              nRST,
  add_fp16_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // one op can sit in each cycle from handshake to response pulse, so leave headroom
  localparam int CW  = $clog2(ADD_LAT + 3);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] issue_id;
  logic           tag_v  [ADD_LAT];
  logic [IDW-1:0] tag_id [ADD_LAT];
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  inflight_nxt;

  logic [IDW:0]    cand;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  next_ptr;
  logic            grant_found;
  logic [NREQ-1:0] ready;
  logic            fire;
  logic            resp_any;

  // priority search starting at rr_ptr, wrapping modulo NREQ
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[IDW-1:0];
      end
    end
    ready = '0;
    if (NREQ == 1) begin
      ready[0] = ~bus.hold;
    end else if (!bus.hold && grant_found) begin
      ready[grant_id] = 1'b1;
    end
  end

  assign bus.req_ready = ready;
  assign fire          = |(bus.req_valid & ready);
  assign resp_any      = |bus.resp_valid;
  assign next_ptr      = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
  assign inflight_nxt  = inflight + CW'(fire) - CW'(resp_any);

  // issue register, tag pipe, response capture and occupancy tracking
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      bus.add_start  <= 1'b0;
      bus.add_fp1    <= '0;
      bus.add_fp2    <= '0;
      bus.resp_valid <= '0;
      bus.resp_data  <= '0;
      bus.busy       <= 1'b0;
      rr_ptr         <= '0;
      issue_id       <= '0;
      inflight       <= '0;
      for (int k = 0; k < ADD_LAT; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= '0;
      end
    end else begin
      bus.add_start <= fire;
      if (fire) begin
        bus.add_fp1 <= bus.req_a[16*grant_id +: 16];
        bus.add_fp2 <= bus.req_b[16*grant_id +: 16];
        issue_id    <= grant_id;
        if (NREQ > 1) begin
          rr_ptr <= next_ptr;
        end
      end
      // the issue register is the entry stage, so the head lines up with add_out
      tag_v[0]  <= bus.add_start;
      tag_id[0] <= issue_id;
      for (int k = 1; k < ADD_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      bus.resp_valid <= '0;
      if (tag_v[ADD_LAT-1]) begin
        bus.resp_valid <= NREQ'(1) << tag_id[ADD_LAT-1];
        bus.resp_data  <= bus.add_out;
      end
      inflight <= inflight_nxt;
      bus.busy <= (inflight_nxt != '0);
    end
  end
endmodule
